// File: rtl/forthsuper_pkg.sv
// rtl/forthsuper_pkg.sv - shared stack command encodings, FSM states and default sizes
//
// Purpose: single source for the stack_ops command encoding, the data-stack
// FSM state type and the default cell / pointer widths used by data_stack.
// Ports: none (package).

package forthsuper_pkg;

  localparam int DSZ_DEF = 32;  // default cell width in bits
  localparam int SSZ_DEF = 6;   // default stack-pointer width

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_PICK = 2'd3
  } stack_ops_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } ds_state_t;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - 2^AW x DW cell store, one write port, one registered read port
//
// Purpose: backing memory for the cells below TOS. Reads return one cycle
// after i_re is sampled; contents are never cleared.
// Ports:
//   clk      - clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_re     - read enable
//   i_raddr  - read address
//   o_rdata  - read data, valid the cycle after i_re

module stack_ram #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_stack.sv
// rtl/data_stack.sv - Forth data stack with registered TOS and memory-backed cells
//
// Purpose: stack of DSZ-bit cells, capacity 2^SSZ-1. TOS lives in s0, cells
// 1..sp-1 in stack_ram at addresses sp-2 down to 0. POP (sp>=2) and PICK n>=1
// take two cycles (IDLE then FETCH); other ops take one.
// Optional feature: define FORTHSUPER_STACK_GUARD_EN to reject overflow,
// underflow and bad PICK indices and raise the sticky err flag.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   op    - stack_ops command (NOP/PUSH/POP/PICK), sampled only when busy=0
//   vi    - PUSH value or PICK index n
//   s0    - top of stack
//   sp    - number of cells on the stack
//   busy  - high during FETCH
//   empty - sp==0
//   full  - sp==2^SSZ-1
//   err   - sticky overflow/underflow/bad-index flag (0 without the guard)

module data_stack
  import forthsuper_pkg::*;
#(
  parameter int DSZ = DSZ_DEF,
  parameter int SSZ = SSZ_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] s0,
  output logic [SSZ-1:0] sp,
  output logic           busy,
  output logic           empty,
  output logic           full,
  output logic           err
);

  ds_state_t      r_state, w_state_n;
  logic [SSZ-1:0] r_sp, w_sp_n;
  logic [DSZ-1:0] r_s0, w_s0_n;
  logic           r_pick, w_pick_n;  // FETCH belongs to a PICK (sp grows on completion)

  stack_ops_t     w_op;
  logic [SSZ-1:0] w_top;             // address of the cell just below TOS when TOS is pushed down
  logic           w_we, w_re;
  logic [SSZ-1:0] w_waddr, w_raddr;
  logic [DSZ-1:0] w_wdata, w_rdata;
  logic           w_push_ok, w_pop_ok, w_pick_ok;

  assign w_op  = stack_ops_t'(op);
  assign w_top = r_sp - SSZ'(1);

  assign busy  = (r_state == ST_FETCH);
  assign empty = (r_sp == '0);
  assign full  = (r_sp == '1);
  assign s0    = r_s0;
  assign sp    = r_sp;

`ifdef FORTHSUPER_STACK_GUARD_EN
  logic r_err;
  logic w_reject;

  // Any PICK grows the stack, so it is an overflow when full as well.
  assign w_push_ok = !full;
  assign w_pop_ok  = !empty;
  assign w_pick_ok = !full && (vi < DSZ'(r_sp));

  assign w_reject = (r_state == ST_IDLE) &&
                    (((w_op == OP_PUSH) && !w_push_ok) ||
                     ((w_op == OP_POP)  && !w_pop_ok)  ||
                     ((w_op == OP_PICK) && !w_pick_ok));

  always_ff @(posedge clk) begin
    if (rst)           r_err <= 1'b0;
    else if (w_reject) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_push_ok = 1'b1;
  assign w_pop_ok  = 1'b1;
  assign w_pick_ok = 1'b1;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_sp_n    = r_sp;
    w_s0_n    = r_s0;
    w_pick_n  = r_pick;
    w_we      = 1'b0;
    w_waddr   = w_top;
    w_wdata   = r_s0;
    w_re      = 1'b0;
    w_raddr   = w_top;
    case (r_state)
      ST_IDLE: begin
        case (w_op)
          OP_PUSH: begin
            if (w_push_ok) begin
              w_we   = (r_sp != '0);  // an empty stack has no old TOS to spill
              w_s0_n = vi;
              w_sp_n = r_sp + SSZ'(1);
            end
          end
          OP_POP: begin
            if (w_pop_ok) begin
              w_sp_n = r_sp - SSZ'(1);
              if (r_sp >= SSZ'(2)) begin
                w_re      = 1'b1;
                w_raddr   = r_sp - SSZ'(2);
                w_pick_n  = 1'b0;
                w_state_n = ST_FETCH;
              end
            end
          end
          OP_PICK: begin
            if (w_pick_ok) begin
              if (vi == '0) begin
                // DUP: spill TOS, keep s0 as the new TOS
                w_we   = (r_sp != '0);
                w_sp_n = r_sp + SSZ'(1);
              end else begin
                // Spill TOS to sp-1 while reading sp-1-n: addresses never coincide
                w_we      = 1'b1;
                w_re      = 1'b1;
                w_raddr   = w_top - vi[SSZ-1:0];
                w_pick_n  = 1'b1;
                w_state_n = ST_FETCH;
              end
            end
          end
          default: ;
        endcase
      end
      ST_FETCH: begin
        w_s0_n    = w_rdata;
        if (r_pick) w_sp_n = r_sp + SSZ'(1);
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sp    <= '0;
      r_s0    <= '0;
      r_pick  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sp    <= w_sp_n;
      r_s0    <= w_s0_n;
      r_pick  <= w_pick_n;
    end
  end

  stack_ram #(
    .DW (DSZ),
    .AW (SSZ)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

endmodule
